// File: rtl/cmac_link_monitor.sv
// Per-port CMAC link qualification: CDC sync, debounce to UP, flap counting and restart requests.
// Optional auto-restart on prolonged DOWN: define CMAC_LINK_MONITOR_AUTO_RESTART_EN.
module cmac_link_monitor #(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned SYNC_STAGES     = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned RESTART_TIMEOUT = 1000000
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [NUM_PORTS-1:0]      rx_aligned_async,
  input  logic [NUM_PORTS-1:0]      rx_gt_locked_async,
  input  logic                      stats_clear,
  output logic [NUM_PORTS-1:0]      link_up,
  output logic                      all_links_up,
  output logic [NUM_PORTS-1:0]      restart_req,
  output logic [16*NUM_PORTS-1:0]   flap_count
);

  localparam int unsigned QW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned FW = 16;

  typedef enum logic [1:0] {
    ST_DOWN    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_UP      = 2'd2
`ifdef CMAC_LINK_MONITOR_AUTO_RESTART_EN
    ,ST_RESTART = 2'd3
`endif
  } state_t;

  // Reject parameter values the counters cannot honour.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cmac_link_monitor: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("cmac_link_monitor: DEBOUNCE_CYCLES must be >= 1");
  end
  if (RESTART_TIMEOUT < 2) begin : g_bad_timeout
    $error("cmac_link_monitor: RESTART_TIMEOUT must be >= 2");
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [SYNC_STAGES-1:0] aligned_sync;
    logic [SYNC_STAGES-1:0] locked_sync;
    logic                   good;
    state_t                 state_q, state_d;
    logic [QW-1:0]          qual_q, qual_d;
    logic [FW-1:0]          flap_q, flap_d;
    logic                   flap_evt;
`ifdef CMAC_LINK_MONITOR_AUTO_RESTART_EN
    localparam int unsigned TW = $clog2(RESTART_TIMEOUT);
    logic [TW-1:0]          timer_q, timer_d;
`endif

    // Independent synchronizer per asynchronous status bit.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
        aligned_sync <= '0;
        locked_sync  <= '0;
      end else begin
        aligned_sync <= {aligned_sync[SYNC_STAGES-2:0], rx_aligned_async[p]};
        locked_sync  <= {locked_sync[SYNC_STAGES-2:0], rx_gt_locked_async[p]};
      end
    end

    assign good = aligned_sync[SYNC_STAGES-1] & locked_sync[SYNC_STAGES-1];

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
        state_q <= ST_DOWN;
        qual_q  <= '0;
        flap_q  <= '0;
`ifdef CMAC_LINK_MONITOR_AUTO_RESTART_EN
        timer_q <= '0;
`endif
      end else begin
        state_q <= state_d;
        qual_q  <= qual_d;
        flap_q  <= flap_d;
`ifdef CMAC_LINK_MONITOR_AUTO_RESTART_EN
        timer_q <= timer_d;
`endif
      end
    end

    always_comb begin
      state_d  = state_q;
      qual_d   = qual_q;
      flap_evt = 1'b0;
`ifdef CMAC_LINK_MONITOR_AUTO_RESTART_EN
      timer_d  = timer_q;
`endif
      unique case (state_q)
        ST_DOWN: begin
          if (good) begin
            state_d = ST_QUALIFY;
            qual_d  = '0;
`ifdef CMAC_LINK_MONITOR_AUTO_RESTART_EN
            timer_d = '0;
          end else if (timer_q == TW'(RESTART_TIMEOUT - 1)) begin
            state_d = ST_RESTART;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
`endif
          end
        end
        ST_QUALIFY: begin
          if (!good) begin
            state_d = ST_DOWN;
`ifdef CMAC_LINK_MONITOR_AUTO_RESTART_EN
            timer_d = '0;
`endif
          end else if (qual_q == QW'(DEBOUNCE_CYCLES - 1)) begin
            state_d = ST_UP;
          end else begin
            qual_d = qual_q + QW'(1);
          end
        end
        ST_UP: begin
          if (!good) begin
            state_d  = ST_DOWN;
            flap_evt = 1'b1;
`ifdef CMAC_LINK_MONITOR_AUTO_RESTART_EN
            timer_d  = '0;
`endif
          end
        end
`ifdef CMAC_LINK_MONITOR_AUTO_RESTART_EN
        ST_RESTART: begin
          state_d = ST_DOWN;
          timer_d = '0;
        end
`endif
        default: begin
          state_d = ST_DOWN;
        end
      endcase

      // A clear on the same cycle as a flap leaves the counter at zero.
      flap_d = flap_q;
      if (stats_clear) begin
        flap_d = '0;
      end else if (flap_evt && (flap_q != {FW{1'b1}})) begin
        flap_d = flap_q + FW'(1);
      end
    end

    assign link_up[p]              = (state_q == ST_UP);
    assign flap_count[FW*p +: FW]  = flap_q;
`ifdef CMAC_LINK_MONITOR_AUTO_RESTART_EN
    assign restart_req[p]          = (state_q == ST_RESTART);
`else
    assign restart_req[p]          = 1'b0;
`endif
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      all_links_up <= 1'b0;
    end else begin
      all_links_up <= &link_up;
    end
  end

endmodule
